// File: rtl/ps2_scan_decoder_pkg.sv
// Shared PS/2 Set-2 constants, decoder state encoding and the key event record
// used by the scan decoder and its event presenter.
package ps2_scan_decoder_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVF0   = 8'h00;
  localparam logic [7:0] PS2_OVF1   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } ps2_dec_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       make;
    logic       ext;
  } key_event_t;

  // Keyboard housekeeping bytes that never represent a key
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK)  || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_OVF0) || (b == PS2_OVF1);
  endfunction

endpackage

// File: rtl/ps2_event_stretcher.sv
// Presents decoded key events as a stretched valid level followed by a
// mandatory low gap, with a single pending slot for events arriving meanwhile.
module ps2_event_stretcher
  import ps2_scan_decoder_pkg::*;
#(
  parameter int STRETCH_CYCLES = 4,
  parameter int GAP_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid_i,
  input  logic [7:0] ev_code_i,
  input  logic       ev_make_i,
  input  logic       ev_ext_i,
  output logic [7:0] cur_code_o,
  output logic       cur_make_o,
  output logic       cur_ext_o,
  output logic       cur_valid_o,
  output logic [7:0] drop_count_o
);

  localparam int MAXC = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  key_event_t     ev;
  key_event_t     cur_q, cur_d, pend_q, pend_d;
  logic           act_q, act_d, gap_q, gap_d, pend_vld_q, pend_vld_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     drop_q, drop_d;
  logic           can_start;

  assign ev = '{code: ev_code_i, make: ev_make_i, ext: ev_ext_i};
  // Last gap cycle counts as free so the next pulse rises right after the gap
  assign can_start = (!act_q && !gap_q) || (gap_q && cnt_q == '0);

  always_comb begin
    act_d      = act_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = drop_q;

    if (act_q) begin
      if (cnt_q == '0) begin
        act_d = 1'b0;
        gap_d = 1'b1;
        cnt_d = GAP_LD;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end else if (gap_q) begin
      if (cnt_q == '0) gap_d = 1'b0;
      else             cnt_d = cnt_q - ONE;
    end

    if (can_start && pend_vld_q) begin
      cur_d      = pend_q;
      act_d      = 1'b1;
      gap_d      = 1'b0;
      cnt_d      = STRETCH_LD;
      pend_vld_d = 1'b0;
    end

    // A pending slot being drained this cycle can take the new event
    if (ev_valid_i) begin
      if (can_start && !pend_vld_q) begin
        cur_d = ev;
        act_d = 1'b1;
        gap_d = 1'b0;
        cnt_d = STRETCH_LD;
      end else if (!pend_vld_q || can_start) begin
        pend_d     = ev;
        pend_vld_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= 1'b0;
      gap_q      <= 1'b0;
      cnt_q      <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      act_q      <= act_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
    end
  end

  assign cur_code_o   = cur_q.code;
  assign cur_make_o   = cur_q.make;
  assign cur_ext_o    = cur_q.ext;
  assign cur_valid_o  = act_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 byte decoder: folds E0/F0/E1 prefix sequences into single key
// events and hands them to the stretcher for the slower game clock domain.
module ps2_scan_decoder
  import ps2_scan_decoder_pkg::*;
#(
  parameter int STRETCH_CYCLES = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] current_scan_code,
  output logic       current_make_break,
  output logic       current_extended,
  output logic       key_event_valid,
  output logic [7:0] err_count,
  output logic [7:0] drop_count
);

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  ps2_dec_state_t state_q, state_d;
  logic [2:0]     skip_q, skip_d;
  logic [19:0]    tmo_q, tmo_d;
  logic [7:0]     err_q, err_d;
  logic           ev_valid;
  key_event_t     ev;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    ev_valid = 1'b0;
    ev       = '0;

    if (rx_err) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end else if (rx_valid) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_PREFIX_EXT)        state_d = ST_EXT;
          else if (rx_byte == PS2_PREFIX_BRK)   state_d = ST_BRK;
          else if (rx_byte == PS2_PREFIX_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = 3'd7;
          end else if (!is_status(rx_byte)) begin
            ev_valid = 1'b1;
            ev       = '{code: rx_byte, make: 1'b1, ext: 1'b0};
          end
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (rx_byte == PS2_PREFIX_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_byte != PS2_PREFIX_EXT && rx_byte != PS2_PREFIX_PAUSE &&
                       !is_status(rx_byte)) begin
            ev_valid = 1'b1;
            ev       = '{code: rx_byte, make: 1'b1, ext: 1'b1};
          end
        end
        ST_BRK: begin
          state_d  = ST_IDLE;
          ev_valid = 1'b1;
          ev       = '{code: rx_byte, make: 1'b0, ext: 1'b0};
        end
        ST_EXT_BRK: begin
          state_d  = ST_IDLE;
          ev_valid = 1'b1;
          ev       = '{code: rx_byte, make: 1'b0, ext: 1'b1};
        end
        ST_SKIP: begin
          // Pause is E1 plus seven trailing bytes, none of which is a key
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  ps2_event_stretcher #(
    .STRETCH_CYCLES(STRETCH_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES)
  ) u_stretch (
    .clk         (clk),
    .rst_n       (rst_n),
    .ev_valid_i  (ev_valid),
    .ev_code_i   (ev.code),
    .ev_make_i   (ev.make),
    .ev_ext_i    (ev.ext),
    .cur_code_o  (current_scan_code),
    .cur_make_o  (current_make_break),
    .cur_ext_o   (current_extended),
    .cur_valid_o (key_event_valid),
    .drop_count_o(drop_count)
  );

  assign err_count = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: expected events with their rise cycle
// are queued as bytes are driven and checked when key_event_valid rises.
module tb_ps2_scan_decoder;
  import ps2_scan_decoder_pkg::*;

  localparam int STRETCH = 4;
  localparam int GAP     = 4;
  localparam int TMO     = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] current_scan_code;
  logic       current_make_break;
  logic       current_extended;
  logic       key_event_valid;
  logic [7:0] err_count;
  logic [7:0] drop_count;

  ps2_scan_decoder #(
    .STRETCH_CYCLES(STRETCH),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_byte           (rx_byte),
    .rx_valid          (rx_valid),
    .rx_err            (rx_err),
    .current_scan_code (current_scan_code),
    .current_make_break(current_make_break),
    .current_extended  (current_extended),
    .key_event_valid   (key_event_valid),
    .err_count         (err_count),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       make;
    logic       ext;
    int         rise;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   width = 0;
  logic vld_prev = 1'b0;
  logic pulse_cut = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every rising valid, checks fields, rise
  // cycle and the pulse width when it falls.
  always @(negedge clk) begin
    if (key_event_valid && !vld_prev) begin
      width = 1;
      pulse_cut = 1'b0;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got code=%h make=%b ext=%b at cycle %0d, required no event",
                 current_scan_code, current_make_break, current_extended, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (current_scan_code !== mon_e.code || current_make_break !== mon_e.make ||
            current_extended !== mon_e.ext) begin
          n_fail++;
          $display("FAIL event_fields: got code=%h make=%b ext=%b, required code=%h make=%b ext=%b",
                   current_scan_code, current_make_break, current_extended,
                   mon_e.code, mon_e.make, mon_e.ext);
        end
        n_checks++;
        if (cyc != mon_e.rise) begin
          n_fail++;
          $display("FAIL event_rise_cycle: got %0d, required %0d (code %h)", cyc, mon_e.rise, mon_e.code);
        end
      end
    end else if (key_event_valid) begin
      width++;
    end else if (vld_prev && !pulse_cut) begin
      n_checks++;
      if (width != STRETCH) begin
        n_fail++;
        $display("FAIL pulse_width: got %0d, required %0d", width, STRETCH);
      end
    end
    vld_prev = key_event_valid;
  end

  task automatic expect_ev(input logic [7:0] code, input logic make, input logic ext, input int rise);
    exp_t e;
    e.code = code; e.make = make; e.ext = ext; e.rise = rise;
    sb.push_back(e);
  endtask

  // Called at posedge+1; byte is sampled on the next posedge
  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    rx_byte  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #3;
    n_checks++;
    if ({current_scan_code, current_make_break, current_extended, key_event_valid,
         err_count, drop_count} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got code=%h mb=%b ext=%b vld=%b err=%0d drop=%0d, required all 0",
               current_scan_code, current_make_break, current_extended, key_event_valid,
               err_count, drop_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    n_checks++;
    if (key_event_valid !== 1'b0 || current_scan_code !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got vld=%b code=%h, required 0/00", key_event_valid, current_scan_code);
    end
  endtask

  task automatic test_make;
    expect_ev(8'h1C, 1'b1, 1'b0, cyc + 1);
    send(8'h1C);
    idle(12);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL make_missing: got %0d outstanding events, required 0", sb.size());
    end
    n_checks++;
    if (current_scan_code !== 8'h1C || current_make_break !== 1'b1) begin
      n_fail++;
      $display("FAIL make_hold: got code=%h mb=%b after pulse, required 1C/1", current_scan_code, current_make_break);
    end
  endtask

  task automatic test_break_ext;
    send(8'hF0);
    expect_ev(8'h1C, 1'b0, 1'b0, cyc + 1);
    send(8'h1C);
    idle(12);
    send(8'hE0);
    expect_ev(8'h6B, 1'b1, 1'b1, cyc + 1);
    send(8'h6B);
    idle(12);
    send(8'hE0);
    send(8'hF0);
    expect_ev(8'h6B, 1'b0, 1'b1, cyc + 1);
    send(8'h6B);
    idle(12);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL break_ext_missing: got %0d outstanding events, required 0", sb.size());
    end
  endtask

  task automatic test_status;
    send(8'hAA);
    send(8'hFA);
    send(8'hE0);
    send(8'hFE);
    expect_ev(8'h1C, 1'b1, 1'b0, cyc + 1);
    send(8'h1C);
    idle(12);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL status_missing: got %0d outstanding events, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int c;
    c = cyc;
    expect_ev(8'h1C, 1'b1, 1'b0, c + 1);
    expect_ev(8'h32, 1'b1, 1'b0, c + 1 + STRETCH + GAP);
    send(8'h1C);
    send(8'h32);
    send(8'h21);
    idle(20);
    n_checks++;
    if (drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_count: got %0d, required 1", drop_count);
    end
    n_checks++;
    if (sb.size() != 0 || current_scan_code !== 8'h32) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d outstanding, code=%h, required 0, 32", sb.size(), current_scan_code);
    end
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) send(seq[i]);
    expect_ev(8'h1C, 1'b1, 1'b0, cyc + 1);
    send(8'h1C);
    idle(12);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pause_missing: got %0d outstanding events, required 0", sb.size());
    end
  endtask

  task automatic test_error;
    send(8'hE0);
    send(8'hF0, 1'b1);
    expect_ev(8'h6B, 1'b1, 1'b0, cyc + 1);
    send(8'h6B);
    idle(12);
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL err_count: got %0d, required 1", err_count);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL error_missing: got %0d outstanding events, required 0", sb.size());
    end
  endtask

  task automatic test_timeout;
    send(8'hF0);
    idle(TMO - 24);
    expect_ev(8'h1C, 1'b0, 1'b0, cyc + 1);
    send(8'h1C);
    idle(12);
    send(8'hF0);
    idle(TMO + 36);
    expect_ev(8'h1C, 1'b1, 1'b0, cyc + 1);
    send(8'h1C);
    idle(12);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_missing: got %0d outstanding events, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    expect_ev(8'h1C, 1'b1, 1'b0, cyc + 1);
    send(8'h1C);
    send(8'h32);
    idle(1);
    pulse_cut = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (key_event_valid !== 1'b0 || current_scan_code !== 8'h00 || current_make_break !== 1'b0 ||
        err_count !== 8'd0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got vld=%b code=%h mb=%b err=%0d drop=%0d, required all 0",
               key_event_valid, current_scan_code, current_make_break, err_count, drop_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(20);
    expect_ev(8'h21, 1'b1, 1'b0, cyc + 1);
    send(8'h21);
    idle(12);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_recovery: got %0d outstanding events, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break_ext();
    test_status();
    test_back_to_back();
    test_pause();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
